// File: rtl/mx_block_acc.sv
// Block accumulator that sums one MX block of signed lane products and attaches the combined E8M0 scale.
// Optional MX_BLOCK_ACC_FLUSH_EN adds an i_flush input that abandons the partial block.
module mx_block_acc #(
  parameter int exp_width   = 5,
  parameter int man_width   = 2,
  parameter int prd_width   = 2 * ((1 << exp_width) + man_width),
  parameter int lanes       = 4,
  parameter int block_size  = 32,
  parameter int scale_width = 8,
  parameter int acc_width   = prd_width + $clog2(block_size)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
`ifdef MX_BLOCK_ACC_FLUSH_EN
  input  logic                                 i_flush,
`endif
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [lanes*prd_width-1:0]           i_prd,
  input  logic [scale_width-1:0]               i_scale0,
  input  logic [scale_width-1:0]               i_scale1,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic signed [acc_width-1:0]          o_acc,
  output logic signed [scale_width+1:0]        o_scale,
  output logic                                 o_nan
);

  localparam int beats     = block_size / lanes;
  localparam int cnt_width = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [cnt_width-1:0]     last_cnt   = cnt_width'(beats - 1);
  localparam logic [scale_width+1:0]   twice_bias = (scale_width + 2)'(2 * ((1 << (scale_width - 1)) - 1));

  logic [cnt_width-1:0]          cnt;
  logic signed [acc_width-1:0]   acc;
  logic signed [acc_width-1:0]   lane_sum;
  logic signed [acc_width-1:0]   total;
  logic signed [prd_width-1:0]   lane_prd;
  logic [scale_width-1:0]        scale0_q, scale1_q;
  logic [scale_width-1:0]        scale0_blk, scale1_blk;
  logic [scale_width+1:0]        scale_comb;
  logic                          nan_comb;
  logic                          first_beat, last_beat, accept, flush;

`ifdef MX_BLOCK_ACC_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == last_cnt);
  // Only the closing beat stalls, and only while the previous result is still unconsumed.
  assign o_ready    = !(last_beat && o_valid && !i_ready) && !flush;
  assign accept     = i_valid && o_ready;

  always_comb begin
    lane_sum = '0;
    lane_prd = '0;
    for (int i = 0; i < lanes; i++) begin
      lane_prd = i_prd[i*prd_width +: prd_width];
      lane_sum = lane_sum + {{(acc_width - prd_width){lane_prd[prd_width-1]}}, lane_prd};
    end
  end

  // On the first beat the scales are taken straight from the inputs so a one-beat block works.
  always_comb begin
    total      = first_beat ? lane_sum : acc + lane_sum;
    scale0_blk = first_beat ? i_scale0 : scale0_q;
    scale1_blk = first_beat ? i_scale1 : scale1_q;
    scale_comb = {2'b00, scale0_blk} + {2'b00, scale1_blk} - twice_bias;
    nan_comb   = (scale0_blk == '1) || (scale1_blk == '1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      scale0_q <= '0;
      scale1_q <= '0;
      o_valid  <= 1'b0;
      o_acc    <= '0;
      o_scale  <= '0;
      o_nan    <= 1'b0;
    end else begin
      if (flush) begin
        cnt <= '0;
        acc <= '0;
      end else if (accept) begin
        cnt <= last_beat ? '0 : cnt + cnt_width'(1);
        acc <= total;
        if (first_beat) begin
          scale0_q <= i_scale0;
          scale1_q <= i_scale1;
        end
      end
      // A new result may load in the same cycle the old one is popped.
      if (accept && last_beat) begin
        o_valid <= 1'b1;
        o_acc   <= total;
        o_scale <= scale_comb;
        o_nan   <= nan_comb;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mx_block_acc.sv
// Scoreboard bench for mx_block_acc: driver pushes block-level expectations, monitor pops on output handshake.
module tb_mx_block_acc;

  localparam int PRD_W   = 68;
  localparam int LANES   = 4;
  localparam int BLOCK   = 32;
  localparam int BEATS   = BLOCK / LANES;
  localparam int ACC_W   = 73;
  localparam int SCALE_W = 8;

  logic                       clk;
  logic                       rst_n;
  logic                       i_valid;
  logic                       o_ready;
  logic [LANES*PRD_W-1:0]     i_prd;
  logic [SCALE_W-1:0]         i_scale0, i_scale1;
  logic                       o_valid;
  logic                       i_ready;
  logic signed [ACC_W-1:0]    o_acc;
  logic signed [SCALE_W+1:0]  o_scale;
  logic                       o_nan;
`ifdef MX_BLOCK_ACC_FLUSH_EN
  logic                       i_flush;
`endif

  typedef struct {
    logic signed [ACC_W-1:0]   acc;
    logic signed [SCALE_W+1:0] scale;
    logic                      nan;
  } exp_t;

  exp_t                      expQ[$];
  logic signed [PRD_W-1:0]   blockPrd[$];
  logic [SCALE_W-1:0]        blkS0, blkS1;
  int                        beatIdx;
  int                        testsRun;
  int                        testsFailed;
  bit                        randReady;

  mx_block_acc dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
`ifdef MX_BLOCK_ACC_FLUSH_EN
    .i_flush  (i_flush),
`endif
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_prd    (i_prd),
    .i_scale0 (i_scale0),
    .i_scale1 (i_scale1),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_acc    (o_acc),
    .o_scale  (o_scale),
    .o_nan    (o_nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic signed [ACC_W-1:0] act,
                             input logic signed [ACC_W-1:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: a block result is the plain signed sum of its 32 products plus scale arithmetic.
  function automatic exp_t blockResult(input logic [SCALE_W-1:0] s0, input logic [SCALE_W-1:0] s1);
    exp_t r;
    logic signed [ACC_W-1:0] s;
    int sc;
    s = '0;
    foreach (blockPrd[k]) s = s + {{(ACC_W-PRD_W){blockPrd[k][PRD_W-1]}}, blockPrd[k]};
    sc      = int'(s0) + int'(s1) - 254;
    r.acc   = s;
    r.scale = sc[SCALE_W+1:0];
    r.nan   = (s0 == 8'hFF) || (s1 == 8'hFF);
    return r;
  endfunction

  task automatic modelBeat(input logic [LANES*PRD_W-1:0] prd, input logic [SCALE_W-1:0] s0,
                           input logic [SCALE_W-1:0] s1);
    if (beatIdx == 0) begin
      blkS0 = s0;
      blkS1 = s1;
    end
    for (int l = 0; l < LANES; l++) blockPrd.push_back(prd[l*PRD_W +: PRD_W]);
    beatIdx++;
    if (beatIdx == BEATS) begin
      expQ.push_back(blockResult(blkS0, blkS1));
      blockPrd.delete();
      beatIdx = 0;
    end
  endtask

  task automatic applyStimulus(input logic [LANES*PRD_W-1:0] prd, input logic [SCALE_W-1:0] s0,
                               input logic [SCALE_W-1:0] s1);
    bit accepted;
    accepted = 0;
    i_valid  = 1'b1;
    i_prd    = prd;
    i_scale0 = s0;
    i_scale1 = s1;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      if (o_ready) begin
        accepted = 1;
        modelBeat(prd, s0, s1);
      end
      @(posedge clk);
      #1;
      if (randReady) i_ready = 1'($urandom_range(0, 1));
    end
    i_valid = 1'b0;
    if (!accepted) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL beat_accept: got no acceptance, expected within 200 cycles");
    end
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (randReady) i_ready = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic logic [LANES*PRD_W-1:0] uniformBeat(input logic signed [PRD_W-1:0] v);
    logic [LANES*PRD_W-1:0] b;
    for (int l = 0; l < LANES; l++) b[l*PRD_W +: PRD_W] = v;
    return b;
  endfunction

  function automatic logic signed [PRD_W-1:0] randPrd();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PRD_W-1:0];
  endfunction

  task automatic sendBlock(input logic signed [PRD_W-1:0] v, input logic [SCALE_W-1:0] s0,
                           input logic [SCALE_W-1:0] s1, input int nBeats);
    for (int b = 0; b < nBeats; b++) applyStimulus(uniformBeat(v), s0, s1);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    expQ.delete();
    blockPrd.delete();
    beatIdx = 0;
    checkOutput("reset o_valid", ACC_W'(o_valid), '0);
    checkOutput("reset o_acc", o_acc, '0);
    checkOutput("reset o_scale", ACC_W'(o_scale), '0);
    checkOutput("reset o_nan", ACC_W'(o_nan), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every output handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_result: got o_acc %0d, expected no result", o_acc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("result o_acc", o_acc, e.acc);
        checkOutput("result o_scale", ACC_W'(o_scale), ACC_W'(e.scale));
        checkOutput("result o_nan", ACC_W'(o_nan), ACC_W'(e.nan));
      end
    end
  end

  initial begin
    logic [LANES*PRD_W-1:0]  beat;
    logic signed [PRD_W-1:0] maxMag;
    testsRun    = 0;
    testsFailed = 0;
    beatIdx     = 0;
    randReady   = 0;
    rst_n       = 1'b0;
    i_valid     = 1'b0;
    i_prd       = '0;
    i_scale0    = '0;
    i_scale1    = '0;
    i_ready     = 1'b1;
`ifdef MX_BLOCK_ACC_FLUSH_EN
    i_flush     = 1'b0;
`endif
    maxMag      = PRD_W'(1) <<< (PRD_W - 2);

    #3;
    checkOutput("por o_valid", ACC_W'(o_valid), '0);
    checkOutput("por o_acc", o_acc, '0);
    checkOutput("por o_ready", ACC_W'(o_ready), ACC_W'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    sendBlock(PRD_W'(1), 8'd127, 8'd127, BEATS);
    checkOutput("latency o_valid", ACC_W'(o_valid), ACC_W'(1));
    sendBlock(-PRD_W'(3), 8'd130, 8'd120, BEATS);
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < LANES; l++) beat[l*PRD_W +: PRD_W] = randPrd();
      applyStimulus(beat, 8'd255, 8'd10);
    end
    sendBlock(maxMag, 8'd200, 8'd3, BEATS);
    sendBlock(-maxMag, 8'd1, 8'd254, BEATS);
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < LANES; l++)
        beat[l*PRD_W +: PRD_W] = ($urandom_range(0, 3) != 0) ? maxMag : -maxMag;
      applyStimulus(beat, 8'd127, 8'd128);
    end
    idleCycles(3);

    // Backpressure: hold first result, stall on closing beat of second block.
    sendBlock(PRD_W'(5), 8'd127, 8'd127, BEATS);
    i_ready = 1'b0;
    sendBlock(PRD_W'(7), 8'd127, 8'd127, BEATS - 1);
    i_valid = 1'b1;
    i_prd   = uniformBeat(PRD_W'(7));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("stall o_ready", ACC_W'(o_ready), '0);
      checkOutput("held o_acc", o_acc, ACC_W'(160));
      @(posedge clk);
      #1;
    end
    i_ready = 1'b1;
    applyStimulus(uniformBeat(PRD_W'(7)), 8'd127, 8'd127);
    checkOutput("pop_load o_valid", ACC_W'(o_valid), ACC_W'(1));
    checkOutput("pop_load o_acc", o_acc, ACC_W'(224));
    idleCycles(3);

    sendBlock(PRD_W'(4), 8'd127, 8'd127, 5);
    applyReset();
    sendBlock(PRD_W'(2), 8'd127, 8'd127, BEATS);
    idleCycles(2);

`ifdef MX_BLOCK_ACC_FLUSH_EN
    sendBlock(PRD_W'(9), 8'd127, 8'd127, 3);
    i_flush = 1'b1;
    i_valid = 1'b1;
    @(negedge clk);
    checkOutput("flush o_ready", ACC_W'(o_ready), '0);
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    blockPrd.delete();
    beatIdx = 0;
    sendBlock(PRD_W'(1), 8'd127, 8'd127, BEATS);
    idleCycles(2);
`endif

    randReady = 1;
    for (int blk = 0; blk < 6; blk++) begin
      for (int b = 0; b < BEATS; b++) begin
        for (int l = 0; l < LANES; l++) beat[l*PRD_W +: PRD_W] = randPrd();
        applyStimulus(beat, 8'($urandom), 8'($urandom));
        if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
      end
    end
    randReady = 0;
    i_ready   = 1'b1;

    for (int c = 0; c < 200 && (expQ.size() != 0 || o_valid); c++) idleCycles(1);
    checkOutput("drain queue_empty", ACC_W'(expQ.size()), '0);
    checkOutput("drain o_valid", ACC_W'(o_valid), '0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mx_block_acc.md
Name: mx_block_acc

Overview:
- Sits directly downstream of the per-lane MX floating-point multipliers.
- Consumes their fixed-point products, `lanes` per beat, and sums one full MX block of `block_size` products.
- Attaches the combined E8M0 shared scale of the two operand blocks.
- Emits one registered dot-product result per block over a valid/ready handshake, to the scaling/normalisation stage.

Parameters:
- exp_width, 5, element exponent width of the multiplier inputs
- man_width, 2, element mantissa width of the multiplier inputs
- prd_width, 2*((1<<exp_width)+man_width), signed product width per lane (68 at defaults)
- lanes, 4, products accepted per beat; power of two
- block_size, 32, products per MX block; multiple of lanes
- scale_width, 8, E8M0 shared-scale width
- acc_width, prd_width+$clog2(block_size), signed accumulator/result width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid && o_ready
- i_prd  in  lanes*prd_width  packed signed products, lane 0 in LSBs
- i_scale0  in  scale_width  E8M0 shared scale of operand block 0; sampled on first beat of a block
- i_scale1  in  scale_width  E8M0 shared scale of operand block 1; sampled on first beat of a block
- o_valid  out  1  result valid
- i_ready  in  1  result consumed when o_valid && i_ready
- o_acc  out  acc_width  signed block sum
- o_scale  out  scale_width+2  signed combined exponent = scale0+scale1-2*(2^(scale_width-1)-1)
- o_nan  out  1  either sampled scale was all-ones

Behaviour:
- Beats per block: B = block_size/lanes.
- Beat counter cnt runs 0..B-1 and wraps to 0 after the last beat.
- Per accepted beat:
  - Sign-extend every lane to acc_width and sum all lanes combinationally.
  - cnt==0: acc <= lane sum; i_scale0/i_scale1 captured.
  - Otherwise: acc <= acc + lane sum.
- No overflow: acc_width covers block_size worst-case products. Two's-complement, no saturation.
- On acceptance of the beat with cnt==B-1:
  - Final sum (acc + lane sum) and scale result load into output registers.
  - o_valid rises the next cycle. Latency is 1 cycle from the last beat.
  - Accumulator restarts at cnt==0.
- Output register holds o_acc/o_scale/o_nan stable while o_valid && !i_ready.
- o_valid clears on handshake unless a new result loads in the same cycle.
- Back-to-back blocks are allowed.
- o_ready is combinational: o_ready = !(cnt==B-1 && o_valid && !i_ready).
  - Only the final beat of a block stalls, and only while the previous result is still held.
  - Same cycle pop of the old result and load of the new one is legal: o_valid stays 1.
- Scale arithmetic: zero-extend both scales to scale_width+2, add, subtract 2*bias (bias = 127 at defaults).
- o_nan = (scale0 == all-ones) || (scale1 == all-ones). o_acc/o_scale are still produced, and the consumer ignores them when o_nan=1.
- States, encoded by cnt plus o_valid:
  - ACC_EMPTY (cnt any, o_valid=0)
  - ACC_HOLD (o_valid=1)
  - STALL (cnt==B-1, o_valid=1, !i_ready)
- B==1: every beat is both first and last; the rules above still apply.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - cnt=0, acc=0, o_valid=0, o_acc=0, o_scale=0, o_nan=0.
  - Reset mid-block discards the partial sum and any unconsumed result.
- i_prd and scales are ignored when no beat is accepted.

Optional Feature:
- Macro: MX_BLOCK_ACC_FLUSH_EN.
- Defined: adds input port i_flush (1 bit).
  - When high, the next edge sets cnt=0 and acc=0, abandoning the partial block.
  - A beat presented in the same cycle is not accepted: o_ready is forced 0 while i_flush=1.
  - The output register and o_valid are unaffected.
- Undefined: no i_flush port; a block can only end by completing B beats.

Test Plan:
- Defaults, 8 beats of all lanes = 1, scales 127/127, i_ready=1 -> one cycle after beat 8: o_valid=1, o_acc=32, o_scale=0, o_nan=0.
- 8 beats of all lanes = -3, scales 130/120 -> o_acc=-96, o_scale=-4.
- Scale0=255, scale1=10, any products -> o_nan=1.
- Mixed-sign products with maximum magnitude ±(2^(prd_width-2)) for a full block -> exact sum, no wrap at acc_width.
- Backpressure:
  - i_ready=0 after the first result; stream a second block.
  - Required: beats 1-7 accepted, o_ready=0 on beat 8, o_acc stable at the first result.
  - Raise i_ready: pop and load happen in one cycle, o_valid stays 1, o_acc becomes the second sum.
- Reset and flush:
  - Assert i_rst_n=0 after 5 beats -> all outputs 0 immediately; a fresh 8-beat block of 2s gives o_acc=64.
  - With MX_BLOCK_ACC_FLUSH_EN: i_flush after 3 beats, then 8 beats of 1s -> o_acc=32.
